// File: rtl/header_parser_pkg.sv
// Shared definitions for the flow-key header parser.
// Key layout, protocol constants and the key masking helper.
package header_parser_pkg;

    localparam int KEY_WIDTH    = 232;

    localparam int IN_PORT_LSB  = 216;
    localparam int DL_SRC_LSB   = 168;
    localparam int DL_DST_LSB   = 120;
    localparam int DL_TYPE_LSB  = 104;
    localparam int NW_SRC_LSB   = 72;
    localparam int NW_DST_LSB   = 40;
    localparam int NW_PROTO_LSB = 32;
    localparam int TP_SRC_LSB   = 16;
    localparam int TP_DST_LSB   = 0;

    localparam logic [15:0] ETH_IPV4  = 16'h0800;
    localparam logic [7:0]  PROTO_TCP = 8'd6;
    localparam logic [7:0]  PROTO_UDP = 8'd17;
    localparam logic [7:0]  IOQ_CTRL  = 8'hFF;

    typedef enum logic [1:0] {
        MOD_HDRS,
        PARSE,
        WAIT_EOP
    } parse_state_t;

    // Byte-position EOP markers are one-hot; module headers are not.
    function automatic logic is_eop_marker(input logic [7:0] c);
        return (c != 8'd0) && ((c & (c - 8'd1)) == 8'd0);
    endfunction

    function automatic logic [KEY_WIDTH-1:0] mask_key(
        input logic [KEY_WIDTH-1:0] k,
        input logic [3:0]           ihl
    );
        logic [KEY_WIDTH-1:0] m;
        logic [15:0]          dl_type;
        logic [7:0]           proto;
        m       = k;
        dl_type = k[DL_TYPE_LSB +: 16];
        proto   = k[NW_PROTO_LSB +: 8];
        if (dl_type != ETH_IPV4) begin
            m[NW_SRC_LSB +: 32]  = '0;
            m[NW_DST_LSB +: 32]  = '0;
            m[NW_PROTO_LSB +: 8] = '0;
            m[TP_SRC_LSB +: 16]  = '0;
            m[TP_DST_LSB +: 16]  = '0;
        end else if (!(proto == PROTO_TCP || proto == PROTO_UDP)
                     || ihl != 4'd5) begin
            m[TP_SRC_LSB +: 16]  = '0;
            m[TP_DST_LSB +: 16]  = '0;
        end
        return m;
    endfunction

endpackage

// File: rtl/fallthrough_small_fifo.sv
// Small first-word-fall-through FIFO; head word visible on dout
// whenever the FIFO is not empty.
module fallthrough_small_fifo #(
    parameter int WIDTH          = 72,
    parameter int MAX_DEPTH_BITS = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             nearly_full,
    output logic             empty
);

    localparam int DEPTH = 1 << MAX_DEPTH_BITS;
    localparam logic [MAX_DEPTH_BITS:0] FULL_CNT =
        (MAX_DEPTH_BITS+1)'(DEPTH);
    localparam logic [MAX_DEPTH_BITS:0] NEAR_CNT =
        (MAX_DEPTH_BITS+1)'(DEPTH - 1);

    logic [WIDTH-1:0]          mem [DEPTH];
    logic [MAX_DEPTH_BITS-1:0] wr_ptr;
    logic [MAX_DEPTH_BITS-1:0] rd_ptr;
    logic [MAX_DEPTH_BITS:0]   depth;
    logic                      full;
    logic                      do_wr;
    logic                      do_rd;

    assign full        = (depth == FULL_CNT);
    assign empty       = (depth == '0);
    assign nearly_full = (depth >= NEAR_CNT);
    assign do_wr       = wr_en && !full;
    assign do_rd       = rd_en && !empty;
    assign dout        = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            depth  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   depth <= depth + 1'b1;
                2'b01:   depth <= depth - 1'b1;
                default: depth <= depth;
            endcase
        end
    end

endmodule

// File: rtl/header_parser.sv
// Pass-through header parser: forwards packet words unchanged and
// extracts an L2-L4 flow key for the downstream matcher.
module header_parser
    import header_parser_pkg::*;
#(
    parameter int DATA_WIDTH      = 64,
    parameter int CTRL_WIDTH      = DATA_WIDTH / 8,
    parameter int FIFO_DEPTH_BITS = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic                  in_wr,
    output logic                  in_rdy,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic                  out_wr,
    input  logic                  out_rdy,
    output logic [KEY_WIDTH-1:0]  key_data,
    output logic                  key_valid,
    input  logic                  key_rdy
);

    logic [CTRL_WIDTH+DATA_WIDTH-1:0] fifo_dout;
    logic                             fifo_empty;
    logic                             fifo_nearly_full;
    logic [DATA_WIDTH-1:0]            word;
    logic [CTRL_WIDTH-1:0]            ctrl;
    logic                             ctrl_zero;

    parse_state_t         state, state_nx;
    logic [2:0]           cnt, cnt_nx, idx;
    logic                 hdr_seen, hdr_seen_nx;
    logic [KEY_WIDTH-1:0] fld, fld_nx, fld_cap;
    logic [3:0]           ihl, ihl_nx, ihl_cap;
    logic                 key_word;
    logic                 pop;
    logic                 load_key;

    fallthrough_small_fifo #(
        .WIDTH          (CTRL_WIDTH + DATA_WIDTH),
        .MAX_DEPTH_BITS (FIFO_DEPTH_BITS)
    ) u_in_fifo (
        .clk         (clk),
        .reset       (reset),
        .din         ({in_ctrl, in_data}),
        .wr_en       (in_wr),
        .rd_en       (pop),
        .dout        (fifo_dout),
        .nearly_full (fifo_nearly_full),
        .empty       (fifo_empty)
    );

    assign {ctrl, word} = fifo_dout;
    assign ctrl_zero    = (ctrl == '0);
    assign in_rdy       = !fifo_nearly_full;
    assign out_data     = word;
    assign out_ctrl     = ctrl;
    assign out_wr       = pop;

    always_comb begin
        key_word = 1'b0;
        case (state)
            MOD_HDRS: key_word = hdr_seen && is_eop_marker(ctrl);
            PARSE:    key_word = !ctrl_zero || (cnt == 3'd4);
            default:  key_word = 1'b0;
        endcase
    end

    // Hold back only the word that would overwrite an unread key.
    assign pop = !fifo_empty && out_rdy
                 && !(key_valid && !key_rdy && key_word);

    assign idx = (state == MOD_HDRS) ? 3'd0 : cnt;

    // IHL sits in the low nibble of the version/IHL byte of word 1.
    always_comb begin
        fld_cap = fld;
        ihl_cap = ihl;
        case (idx)
            3'd0: begin
                fld_cap[DL_DST_LSB +: 48]      = word[63:16];
                fld_cap[DL_SRC_LSB+32 +: 16]   = word[15:0];
            end
            3'd1: begin
                fld_cap[DL_SRC_LSB +: 32]      = word[63:32];
                fld_cap[DL_TYPE_LSB +: 16]     = word[31:16];
                ihl_cap                        = word[11:8];
            end
            3'd2: fld_cap[NW_PROTO_LSB +: 8]   = word[7:0];
            3'd3: begin
                fld_cap[NW_SRC_LSB +: 32]      = word[47:16];
                fld_cap[NW_DST_LSB+16 +: 16]   = word[15:0];
            end
            3'd4: begin
                fld_cap[NW_DST_LSB +: 16]      = word[63:48];
                fld_cap[TP_SRC_LSB +: 16]      = word[47:32];
                fld_cap[TP_DST_LSB +: 16]      = word[31:16];
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        hdr_seen_nx = hdr_seen;
        fld_nx      = fld;
        ihl_nx      = ihl;
        load_key    = 1'b0;
        if (pop) begin
            case (state)
                MOD_HDRS: begin
                    if (ctrl_zero) begin
                        fld_nx      = fld_cap;
                        ihl_nx      = ihl_cap;
                        cnt_nx      = 3'd1;
                        hdr_seen_nx = 1'b0;
                        state_nx    = PARSE;
                    end else if (key_word) begin
                        load_key = 1'b1;
                    end else begin
                        hdr_seen_nx = 1'b1;
                        if (ctrl == IOQ_CTRL)
                            fld_nx[IN_PORT_LSB +: 16] = word[31:16];
                    end
                end
                PARSE: begin
                    if (!ctrl_zero) begin
                        load_key = 1'b1;
                        cnt_nx   = 3'd0;
                        state_nx = MOD_HDRS;
                    end else begin
                        fld_nx = fld_cap;
                        ihl_nx = ihl_cap;
                        if (cnt == 3'd4) begin
                            load_key = 1'b1;
                            cnt_nx   = 3'd0;
                            state_nx = WAIT_EOP;
                        end else begin
                            cnt_nx = cnt + 3'd1;
                        end
                    end
                end
                WAIT_EOP: begin
                    if (!ctrl_zero) state_nx = MOD_HDRS;
                end
                default: state_nx = MOD_HDRS;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= MOD_HDRS;
            cnt       <= 3'd0;
            hdr_seen  <= 1'b0;
            fld       <= '0;
            ihl       <= 4'd0;
            key_valid <= 1'b0;
            key_data  <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (load_key) begin
                fld       <= '0;
                ihl       <= 4'd0;
                hdr_seen  <= 1'b0;
                key_data  <= mask_key(fld_nx, ihl_nx);
                key_valid <= 1'b1;
            end else begin
                fld      <= fld_nx;
                ihl      <= ihl_nx;
                hdr_seen <= hdr_seen_nx;
                if (key_rdy) key_valid <= 1'b0;
            end
        end
    end

endmodule
